rng_sched: RTL and testbench

Controller and arbiter for the `rng8` dual-LFSR generator. It loads and reseeds the generator, discards a warm-up window after every (re)seed, then shares the per-cycle 16-bit random sample `{rnd1, rnd2}` among `N_REQ` requesters using round-robin arbitration. It sits between `rng8` and the consumers of random bytes. No consumer connects to `rng8` directly.

---
 rtl/rng_pkg.sv | 23 ++
 rtl/rr_arbiter.sv | 32 +++
 rtl/rng_sched.sv | 108 ++++++++++
 tb/tb_rng_sched.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rng_pkg.sv
// Shared types and seed helpers for the rng8 controller; purely declarative, no latency.
// The seed sanitiser is combinational and has no flow control.
package rng_pkg;

   typedef enum logic [1:0] {
      ST_LOAD   = 2'd0,
      ST_WARMUP = 2'd1,
      ST_SERVE  = 2'd2
   } rng_state_t;

   // rng1 locks up on all-zero; rng2 gets ~seed and so locks up on all-ones
   localparam logic [31:0] SEED_ILLEGAL_ZERO = 32'h0000_0000;
   localparam logic [31:0] SEED_ILLEGAL_ONES = 32'hFFFF_FFFF;

   function automatic logic [31:0] sanitize_seed(input logic [31:0] seed,
                                                 input logic [31:0] fallback);
      if (seed == SEED_ILLEGAL_ZERO || seed == SEED_ILLEGAL_ONES) begin
         return fallback;
      end
      return seed;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set req bit at or above ptr, wrapping; zero latency.
// No flow control; any is low when nothing requests.
module rr_arbiter #(
   parameter int N = 4
) (
   input  logic [N-1:0]         req,
   input  logic [$clog2(N)-1:0] ptr,
   output logic                 any,
   output logic [$clog2(N)-1:0] winner
);

   localparam int IW = $clog2(N);
   localparam logic [IW:0] N_L = (IW + 1)'(N);

   logic [N-1:0] rot;
   logic [IW:0]  sum;

   always_comb begin
      rot    = N'({req, req} >> ptr);
      any    = |req;
      winner = '0;
      sum    = '0;
      // descending scan so the lowest rotated offset is the one that sticks
      for (int i = N - 1; i >= 0; i--) begin
         if (rot[i]) begin
            sum    = {1'b0, ptr} + (IW + 1)'(i);
            winner = (sum >= N_L) ? IW'(sum - N_L) : IW'(sum);
         end
      end
   end

endmodule

// File: rtl/rng_sched.sv
// Loads/warms the rng8 LFSR pair and round-robins its {rnd1,rnd2} sample over N_REQ requesters.
// Grant one cycle after req is sampled; no backpressure, a reseed blocks grants until warm-up ends.
module rng_sched
   import rng_pkg::*;
#(
   parameter int          N_REQ        = 4,
   parameter int          WARMUP       = 8,
   parameter logic [31:0] SEED_DEFAULT = 32'hACE1_2468
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [31:0]              seed_in,
   input  logic                     reseed_req,
   output logic                     reseed_busy,
   output logic [31:0]              rng_seed,
   output logic                     rng_reset,
   input  logic [7:0]               rnd1,
   input  logic [7:0]               rnd2,
   input  logic [N_REQ-1:0]         req,
   output logic [N_REQ-1:0]         gnt,
   output logic                     rsp_valid,
   output logic [$clog2(N_REQ)-1:0] rsp_id,
   output logic [15:0]              rsp_data
);

   localparam int IW = $clog2(N_REQ);
   localparam int CW = (WARMUP > 1) ? $clog2(WARMUP) : 1;

   rng_state_t    state, state_next;
   logic [CW-1:0] cnt, cnt_next;
   logic [IW-1:0] ptr, winner, ptr_next;
   logic          any, issue;

   rr_arbiter #(.N(N_REQ)) u_arb (
      .req    (req),
      .ptr    (ptr),
      .any    (any),
      .winner (winner)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= ST_LOAD;
         cnt   <= '0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
      end
   end

   always_comb begin
      state_next  = state;
      cnt_next    = cnt;
      rng_reset   = 1'b0;
      reseed_busy = 1'b1;
      issue       = 1'b0;
      case (state)
         ST_LOAD: begin
            rng_reset  = 1'b1;
            state_next = ST_WARMUP;
            cnt_next   = CW'(WARMUP - 1);
         end
         ST_WARMUP: begin
            if (cnt == '0) state_next = ST_SERVE;
            else           cnt_next   = cnt - CW'(1);
         end
         ST_SERVE: begin
            reseed_busy = 1'b0;
            issue       = any;
         end
         default: state_next = ST_LOAD;
      endcase
      // a reseed wins over both the warm-up sequence and arbitration
      if (reseed_req) begin
         state_next = ST_LOAD;
         issue      = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)          rng_seed <= SEED_DEFAULT;
      else if (reseed_req) rng_seed <= sanitize_seed(seed_in, SEED_DEFAULT);
   end

   assign ptr_next = (winner == IW'(N_REQ - 1)) ? '0 : winner + IW'(1);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ptr       <= '0;
         gnt       <= '0;
         rsp_valid <= 1'b0;
         rsp_id    <= '0;
         rsp_data  <= '0;
      end else if (issue) begin
         ptr       <= ptr_next;
         gnt       <= {{(N_REQ - 1){1'b0}}, 1'b1} << winner;
         rsp_valid <= 1'b1;
         rsp_id    <= winner;
         rsp_data  <= {rnd1, rnd2};
      end else begin
         gnt       <= '0;
         rsp_valid <= 1'b0;
         rsp_id    <= '0;
         rsp_data  <= '0;
      end
   end

endmodule

// File: tb/tb_rng_sched.sv
// Bench for rng_sched: behavioural model feeds a scoreboard queue, plus scenario-specific checks.
module tb_rng_sched;

   localparam logic [31:0] SEED_DEF = 32'hACE1_2468;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] seed_in;
   logic        reseed_req;
   logic        reseed_busy;
   logic [31:0] rng_seed;
   logic        rng_reset;
   logic [7:0]  rnd1, rnd2;
   logic [3:0]  req;
   logic [3:0]  gnt;
   logic        rsp_valid;
   logic [1:0]  rsp_id;
   logic [15:0] rsp_data;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [3:0]  gnt;
      logic [1:0]  id;
      logic [15:0] data;
   } exp_t;
   exp_t exp_q[$];

   // model state: 0 LOAD, 1 WARMUP, 2 SERVE
   int          m_state;
   int          m_cnt;
   int          m_ptr;
   logic [31:0] m_seed;

   always #5 clk = ~clk;

   rng_sched #(.N_REQ(4), .WARMUP(8), .SEED_DEFAULT(SEED_DEF)) dut (
      .clk         (clk),
      .reset       (reset),
      .seed_in     (seed_in),
      .reseed_req  (reseed_req),
      .reseed_busy (reseed_busy),
      .rng_seed    (rng_seed),
      .rng_reset   (rng_reset),
      .rnd1        (rnd1),
      .rnd2        (rnd2),
      .req         (req),
      .gnt         (gnt),
      .rsp_valid   (rsp_valid),
      .rsp_id      (rsp_id),
      .rsp_data    (rsp_data)
   );

   task automatic model_init();
      m_state = 0;
      m_cnt   = 0;
      m_ptr   = 0;
      m_seed  = SEED_DEF;
      exp_q.delete();
   endtask

   // one clock: model predicts, pushes, then the DUT result is popped and compared
   task automatic tick();
      exp_t e;
      int   w;
      rnd1   = 8'($urandom);
      rnd2   = 8'($urandom);
      e.gnt  = '0;
      e.id   = '0;
      e.data = '0;
      if (m_state == 2 && !reseed_req && req != 4'b0) begin
         w = m_ptr;
         while (req[w[1:0]] !== 1'b1) w = (w + 1) % 4;
         e.gnt  = 4'(1 << w);
         e.id   = 2'(w);
         e.data = {rnd1, rnd2};
         m_ptr  = (w + 1) % 4;
      end
      if (reseed_req) begin
         m_state = 0;
         m_seed  = (seed_in == 32'h0 || seed_in == 32'hFFFF_FFFF) ? SEED_DEF : seed_in;
      end else if (m_state == 0) begin
         m_state = 1;
         m_cnt   = 7;
      end else if (m_state == 1) begin
         if (m_cnt == 0) m_state = 2;
         else            m_cnt   = m_cnt - 1;
      end
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      checks++;
      if (gnt !== e.gnt) begin
         errors++;
         $display("FAIL sb_gnt t=%0t: got %b expected %b", $time, gnt, e.gnt);
      end
      checks++;
      if (rsp_valid !== (e.gnt != 4'b0)) begin
         errors++;
         $display("FAIL sb_valid t=%0t: got %b expected %b", $time, rsp_valid, (e.gnt != 4'b0));
      end
      checks++;
      if (rsp_id !== e.id) begin
         errors++;
         $display("FAIL sb_id t=%0t: got %0d expected %0d", $time, rsp_id, e.id);
      end
      checks++;
      if (rsp_data !== e.data) begin
         errors++;
         $display("FAIL sb_data t=%0t: got %h expected %h", $time, rsp_data, e.data);
      end
      checks++;
      if (reseed_busy !== (m_state != 2)) begin
         errors++;
         $display("FAIL sb_busy t=%0t: got %b expected %b", $time, reseed_busy, (m_state != 2));
      end
      checks++;
      if (rng_reset !== (m_state == 0)) begin
         errors++;
         $display("FAIL sb_rng_reset t=%0t: got %b expected %b", $time, rng_reset, (m_state == 0));
      end
      checks++;
      if (rng_seed !== m_seed) begin
         errors++;
         $display("FAIL sb_seed t=%0t: got %h expected %h", $time, rng_seed, m_seed);
      end
   endtask

   // ticks while busy is high; n = number of busy observations, including the current one
   task automatic count_busy(output int n);
      n = 0;
      while (reseed_busy === 1'b1 && n < 40) begin
         n++;
         tick();
      end
   endtask

   task automatic do_reseed(input logic [31:0] s);
      seed_in    = s;
      reseed_req = 1'b1;
      tick();
      reseed_req = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0; seed_in = '0; reseed_req = 1'b0; req = '0; rnd1 = 8'h5A; rnd2 = 8'hC3;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (gnt !== 4'b0)        begin errors++; $display("FAIL rst_gnt: got %b expected 0000", gnt); end
      checks++; if (rsp_valid !== 1'b0)  begin errors++; $display("FAIL rst_valid: got %b expected 0", rsp_valid); end
      checks++; if (rsp_id !== 2'd0)     begin errors++; $display("FAIL rst_id: got %0d expected 0", rsp_id); end
      checks++; if (rsp_data !== 16'h0)  begin errors++; $display("FAIL rst_data: got %h expected 0000", rsp_data); end
      checks++; if (rng_reset !== 1'b1)  begin errors++; $display("FAIL rst_rng_reset: got %b expected 1", rng_reset); end
      checks++; if (reseed_busy !== 1'b1) begin errors++; $display("FAIL rst_busy: got %b expected 1", reseed_busy); end
      checks++; if (rng_seed !== SEED_DEF) begin errors++; $display("FAIL rst_seed: got %h expected %h", rng_seed, SEED_DEF); end
      reset = 1'b1;
      model_init();
   endtask

   task automatic test_startup();
      logic [3:0] exp_seq [8];
      int first, ng;
      exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
      first = -1;
      ng    = 0;
      req   = 4'b1111;
      for (int t = 1; t <= 60 && ng < 8; t++) begin
         tick();
         if (rsp_valid === 1'b1) begin
            if (first < 0) first = t;
            checks++;
            if (gnt !== exp_seq[ng]) begin
               errors++;
               $display("FAIL start_seq[%0d]: got %b expected %b", ng, gnt, exp_seq[ng]);
            end
            ng++;
         end
      end
      checks++;
      if (ng != 8) begin errors++; $display("FAIL start_timeout: got %0d grants expected 8", ng); end
      checks++;
      if (first != 10) begin errors++; $display("FAIL start_first_gnt: got cycle %0d expected 10", first); end
      req = 4'b1010;
   endtask

   task automatic test_rr_skip();
      logic [3:0] exp_seq [3];
      exp_seq = '{4'b0010, 4'b1000, 4'b0010};
      for (int k = 0; k < 3; k++) begin
         tick();
         checks++;
         if (gnt !== exp_seq[k]) begin
            errors++;
            $display("FAIL skip_gnt[%0d]: got %b expected %b", k, gnt, exp_seq[k]);
         end
      end
      req = 4'b0000;
      repeat (2) tick();
      req = 4'b1111;
      tick();
      checks++;
      if (gnt !== 4'b0100) begin errors++; $display("FAIL skip_ptr_hold: got %b expected 0100", gnt); end
      req = 4'b0000;
      tick();
   endtask

   task automatic test_reseed();
      int n;
      req        = 4'b0001;
      do_reseed(32'h1234_5678);
      checks++; if (gnt !== 4'b0)            begin errors++; $display("FAIL reseed_no_gnt: got %b expected 0000", gnt); end
      checks++; if (rng_seed !== 32'h1234_5678) begin errors++; $display("FAIL reseed_seed: got %h expected 12345678", rng_seed); end
      checks++; if (rng_reset !== 1'b1)      begin errors++; $display("FAIL reseed_pulse: got %b expected 1", rng_reset); end
      count_busy(n);
      checks++; if (n != 9) begin errors++; $display("FAIL reseed_busy_len: got %0d expected 9", n); end
      tick();
      checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL reseed_resume: got %b expected 0001", gnt); end
      req = 4'b0000;
      tick();
   endtask

   task automatic test_sanitize();
      logic [31:0] s_in  [3];
      logic [31:0] s_exp [3];
      int n;
      s_in  = '{32'h0000_0000, 32'hDEAD_BEEF, 32'hFFFF_FFFF};
      s_exp = '{SEED_DEF, 32'hDEAD_BEEF, SEED_DEF};
      for (int k = 0; k < 3; k++) begin
         do_reseed(s_in[k]);
         checks++;
         if (rng_seed !== s_exp[k]) begin
            errors++;
            $display("FAIL sanitize[%0d]: got %h expected %h", k, rng_seed, s_exp[k]);
         end
         tick();
      end
      count_busy(n);
   endtask

   task automatic test_warmup_restart();
      int n;
      do_reseed(32'h0BAD_F00D);
      repeat (3) tick();
      do_reseed(32'h0BAD_F00D);
      checks++; if (rng_reset !== 1'b1) begin errors++; $display("FAIL restart_load: got %b expected 1", rng_reset); end
      count_busy(n);
      checks++; if (n != 9) begin errors++; $display("FAIL restart_busy_len: got %0d expected 9", n); end
   endtask

   task automatic test_async_reset();
      req = 4'b1111;
      repeat (3) tick();
      #3;
      reset = 1'b0;
      #1;
      checks++; if (gnt !== 4'b0)        begin errors++; $display("FAIL async_gnt: got %b expected 0000", gnt); end
      checks++; if (rsp_valid !== 1'b0)  begin errors++; $display("FAIL async_valid: got %b expected 0", rsp_valid); end
      checks++; if (rng_reset !== 1'b1)  begin errors++; $display("FAIL async_rng_reset: got %b expected 1", rng_reset); end
      checks++; if (reseed_busy !== 1'b1) begin errors++; $display("FAIL async_busy: got %b expected 1", reseed_busy); end
      checks++; if (rng_seed !== SEED_DEF) begin errors++; $display("FAIL async_seed: got %h expected %h", rng_seed, SEED_DEF); end
      @(posedge clk);
      #1;
      req   = 4'b0000;
      reset = 1'b1;
      model_init();
      repeat (2) tick();
   endtask

   initial begin
      test_reset();
      test_startup();
      test_rr_skip();
      test_reseed();
      test_sanitize();
      test_warmup_restart();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
